// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external RAM sequencer: state encodings,
// default access timing and a small helper for sizing the cycle timer.
package mem_bus_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_RD       = ST_RD,
        S_WR_SETUP = ST_WR_SETUP,
        S_WR_PULSE = ST_WR_PULSE,
        S_WR_HOLD  = ST_WR_HOLD,
        S_DONE     = ST_DONE
    } seq_state_t;

    localparam int RD_CYCLES_DEF = 2;
    localparam int WE_CYCLES_DEF = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ext_ram_sequencer_if.sv
// CPU/decoder side and SRAM pin side of the external RAM sequencer.
// slave = the sequencer, master = the surrounding bus/SRAM environment.
interface ext_ram_sequencer_if #(
    parameter int ADR_W = 16
);
    logic             ram_cs;
    logic             memread;
    logic             memwrite;
    logic [ADR_W-1:0] address;
    logic [7:0]       cpu_dout;
    logic [7:0]       ram_dout;
    logic             wait_n;
    logic             acc_done;
    logic             protocol_err;
    logic [ADR_W-1:0] sram_adr;
    logic             sram_ce_n;
    logic             sram_oe_n;
    logic             sram_we_n;
    logic [7:0]       sram_dq_o;
    logic             sram_dq_oe;
    logic [7:0]       sram_dq_i;

    modport slave (
        input  ram_cs, memread, memwrite, address, cpu_dout, sram_dq_i,
        output ram_dout, wait_n, acc_done, protocol_err, sram_adr,
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_o, sram_dq_oe
    );

    modport master (
        output ram_cs, memread, memwrite, address, cpu_dout, sram_dq_i,
        input  ram_dout, wait_n, acc_done, protocol_err, sram_adr,
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/ext_ram_sequencer_cycle_timer.sv
// Loadable down-counter shared by the read strobe window and the WE pulse.
// zero is decoded from the count register, so it is valid the clock after a load.
module cycle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] count_q;

    // Load has priority; counting stops at zero so the counter never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/ext_ram_sequencer.sv
// Turns one Z80 memory cycle (qualified by ram_cs) into one timed async-SRAM
// access, stretching the CPU with wait_n until the access is finished.
//
// state    | meaning
// IDLE     | waiting for ram_cs with a single strobe
// RD       | CE+OE low, counting read access time
// WR_SETUP | CE low, address/data driven, WE still high
// WR_PULSE | WE low for WE_CYCLES clocks
// WR_HOLD  | WE released, data held one more clock
// DONE     | access finished, waiting for ram_cs to drop
module ext_ram_sequencer
    import mem_bus_pkg::*;
#(
    parameter int ADR_W     = 16,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WE_CYCLES = WE_CYCLES_DEF
) (
    input  logic                clock,
    input  logic                reset,
    ext_ram_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(max_int(RD_CYCLES, WE_CYCLES)) + 1;

    seq_state_t       state_q, state_nxt;
    logic             ce_n_q, ce_n_nxt;
    logic             oe_n_q, oe_n_nxt;
    logic             we_n_q, we_n_nxt;
    logic             dq_oe_q, dq_oe_nxt;
    logic             wait_n_q, wait_n_nxt;
    logic             acc_done_q, acc_done_nxt;
    logic             perr_q, perr_nxt;
    logic [7:0]       dout_q, dout_nxt;
    logic [ADR_W-1:0] adr_q, adr_nxt;
    logic [7:0]       dq_o_q, dq_o_nxt;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt    = state_q;
        ce_n_nxt     = ce_n_q;
        oe_n_nxt     = oe_n_q;
        we_n_nxt     = we_n_q;
        dq_oe_nxt    = dq_oe_q;
        wait_n_nxt   = wait_n_q;
        acc_done_nxt = 1'b0;
        perr_nxt     = perr_q;
        dout_nxt     = dout_q;
        adr_nxt      = adr_q;
        dq_o_nxt     = dq_o_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.ram_cs) begin
                    if (bus.memread && bus.memwrite) begin
                        perr_nxt = 1'b1;
                    end else if (bus.memread) begin
                        state_nxt  = S_RD;
                        adr_nxt    = bus.address;
                        ce_n_nxt   = 1'b0;
                        oe_n_nxt   = 1'b0;
                        wait_n_nxt = 1'b0;
                        tmr_load   = 1'b1;
                        tmr_val    = CNT_W'(RD_CYCLES - 1);
                    end else if (bus.memwrite) begin
                        state_nxt  = S_WR_SETUP;
                        adr_nxt    = bus.address;
                        dq_o_nxt   = bus.cpu_dout;
                        ce_n_nxt   = 1'b0;
                        dq_oe_nxt  = 1'b1;
                        wait_n_nxt = 1'b0;
                    end
                end
            end
            S_RD: begin
                // A dropped ram_cs abandons the read without touching ram_dout.
                if (!bus.ram_cs) begin
                    state_nxt  = S_IDLE;
                    ce_n_nxt   = 1'b1;
                    oe_n_nxt   = 1'b1;
                    wait_n_nxt = 1'b1;
                end else if (tmr_zero) begin
                    state_nxt    = S_DONE;
                    dout_nxt     = bus.sram_dq_i;
                    ce_n_nxt     = 1'b1;
                    oe_n_nxt     = 1'b1;
                    wait_n_nxt   = 1'b1;
                    acc_done_nxt = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_WR_SETUP: begin
                state_nxt = S_WR_PULSE;
                we_n_nxt  = 1'b0;
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(WE_CYCLES - 1);
            end
            S_WR_PULSE: begin
                if (tmr_zero) begin
                    state_nxt = S_WR_HOLD;
                    we_n_nxt  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_WR_HOLD: begin
                state_nxt    = S_DONE;
                ce_n_nxt     = 1'b1;
                dq_oe_nxt    = 1'b0;
                wait_n_nxt   = 1'b1;
                acc_done_nxt = 1'b1;
            end
            S_DONE: begin
                if (!bus.ram_cs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                ce_n_nxt   = 1'b1;
                oe_n_nxt   = 1'b1;
                we_n_nxt   = 1'b1;
                dq_oe_nxt  = 1'b0;
                wait_n_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers; reset releases all strobes immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            wait_n_q   <= 1'b1;
            acc_done_q <= 1'b0;
            perr_q     <= 1'b0;
            dout_q     <= 8'h00;
            adr_q      <= '0;
            dq_o_q     <= 8'h00;
        end else begin
            state_q    <= state_nxt;
            ce_n_q     <= ce_n_nxt;
            oe_n_q     <= oe_n_nxt;
            we_n_q     <= we_n_nxt;
            dq_oe_q    <= dq_oe_nxt;
            wait_n_q   <= wait_n_nxt;
            acc_done_q <= acc_done_nxt;
            perr_q     <= perr_nxt;
            dout_q     <= dout_nxt;
            adr_q      <= adr_nxt;
            dq_o_q     <= dq_o_nxt;
        end
    end

    assign bus.ram_dout     = dout_q;
    assign bus.wait_n       = wait_n_q;
    assign bus.acc_done     = acc_done_q;
    assign bus.protocol_err = perr_q;
    assign bus.sram_adr     = adr_q;
    assign bus.sram_ce_n    = ce_n_q;
    assign bus.sram_oe_n    = oe_n_q;
    assign bus.sram_we_n    = we_n_q;
    assign bus.sram_dq_o    = dq_o_q;
    assign bus.sram_dq_oe   = dq_oe_q;
endmodule

// File: tb/tb_ext_ram_sequencer.sv
// Scoreboard bench for ext_ram_sequencer with a behavioural async SRAM.
module tb_ext_ram_sequencer;
    import mem_bus_pkg::*;

    typedef struct packed {
        logic        rd;
        logic [15:0] adr;
        logic [7:0]  data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ext_ram_sequencer_if #(.ADR_W(16)) bus ();

    ext_ram_sequencer #(.ADR_W(16), .RD_CYCLES(2), .WE_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:65535];
    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_adr] : 8'h00;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   wait_lo = 0;
    int   we_lo = 0;
    int   dqoe_hi = 0;
    int   ce_falls = 0;
    int   acc_cnt = 0;
    int   interlock_viol = 0;
    logic ce_prev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: SRAM write model, strobe activity counters, scoreboard pops on acc_done.
    initial begin
        exp_t e;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h4000] = 8'h5A;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (!bus.wait_n) wait_lo++;
                if (!bus.sram_we_n) we_lo++;
                if (bus.sram_dq_oe) dqoe_hi++;
                if (ce_prev && !bus.sram_ce_n) ce_falls++;
                if ((!bus.sram_we_n && !bus.sram_oe_n) || (bus.sram_dq_oe && !bus.sram_oe_n))
                    interlock_viol++;
                if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
                    mem[bus.sram_adr] = bus.sram_dq_o;
                if (bus.acc_done) begin
                    acc_cnt++;
                    if (sbq.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_acc_done: got acc_done at adr %0h expected none",
                                 bus.sram_adr);
                    end else begin
                        e = sbq.pop_front();
                        chk("acc_adr", 32'(bus.sram_adr), 32'(e.adr));
                        if (e.rd) chk("rd_data", 32'(bus.ram_dout), 32'(e.data));
                        else      chk("wr_mem", 32'(mem[e.adr]), 32'(e.data));
                    end
                end
            end
            ce_prev = bus.sram_ce_n;
        end
    end

    task automatic do_read(input logic [15:0] adr, input logic [7:0] data, input int hold,
                           input string name);
        int w0, c0, a0;
        w0 = wait_lo; c0 = ce_falls; a0 = acc_cnt;
        sbq.push_back('{rd: 1'b1, adr: adr, data: data});
        bus.address = adr;
        bus.ram_cs  = 1'b1;
        bus.memread = 1'b1;
        repeat (hold) tick();
        bus.ram_cs  = 1'b0;
        bus.memread = 1'b0;
        repeat (2) tick();
        chk({name, "_wait_clks"}, 32'(wait_lo - w0), 32'd2);
        chk({name, "_ce_assertions"}, 32'(ce_falls - c0), 32'd1);
        chk({name, "_acc_pulses"}, 32'(acc_cnt - a0), 32'd1);
        chk({name, "_state_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    task automatic do_write(input logic [15:0] adr, input logic [7:0] data);
        int w0, we0, d0, c0, a0;
        w0 = wait_lo; we0 = we_lo; d0 = dqoe_hi; c0 = ce_falls; a0 = acc_cnt;
        sbq.push_back('{rd: 1'b0, adr: adr, data: data});
        bus.address  = adr;
        bus.cpu_dout = data;
        bus.ram_cs   = 1'b1;
        bus.memwrite = 1'b1;
        repeat (6) tick();
        bus.ram_cs   = 1'b0;
        bus.memwrite = 1'b0;
        repeat (2) tick();
        chk("wr_wait_clks", 32'(wait_lo - w0), 32'd4);
        chk("wr_we_clks", 32'(we_lo - we0), 32'd2);
        chk("wr_dqoe_clks", 32'(dqoe_hi - d0), 32'd4);
        chk("wr_ce_assertions", 32'(ce_falls - c0), 32'd1);
        chk("wr_acc_pulses", 32'(acc_cnt - a0), 32'd1);
        chk("wr_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    // Stimulus: directed scenarios with hand-computed expectations.
    initial begin
        int a0, c0;
        reset        = 1'b1;
        bus.ram_cs   = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.address  = 16'h0000;
        bus.cpu_dout = 8'h00;
        repeat (3) tick();
        chk("rst_ctrl", {25'd0, bus.wait_n, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                         bus.sram_dq_oe, bus.acc_done, bus.protocol_err}, 32'b1111000);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'h00);
        chk("rst_sram_adr", 32'(bus.sram_adr), 32'h0);
        chk("rst_dq_o", 32'(bus.sram_dq_o), 32'h00);
        reset = 1'b0;
        tick();

        do_read(16'h1234, 8'hA5, 4, "rd1");
        do_write(16'h8001, 8'h3C);
        chk("wr_model_content", 32'(mem[16'h8001]), 32'h3C);
        do_read(16'h8001, 8'h3C, 4, "rd_back");
        do_read(16'h4000, 8'h5A, 10, "long_rd");

        // Abort in the first RD clock.
        a0 = acc_cnt;
        bus.address = 16'h1234;
        bus.ram_cs  = 1'b1;
        bus.memread = 1'b1;
        tick();
        chk("abort_in_rd", {31'd0, bus.sram_oe_n}, 32'd0);
        bus.ram_cs  = 1'b0;
        bus.memread = 1'b0;
        tick();
        chk("abort_release", {29'd0, bus.sram_ce_n, bus.sram_oe_n, bus.wait_n}, 32'b111);
        repeat (2) tick();
        chk("abort_no_acc", 32'(acc_cnt - a0), 32'd0);
        chk("abort_dout_kept", 32'(bus.ram_dout), 32'h5A);
        chk("abort_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Both strobes with ram_cs.
        c0 = ce_falls;
        bus.ram_cs   = 1'b1;
        bus.memread  = 1'b1;
        bus.memwrite = 1'b1;
        repeat (3) tick();
        chk("perr_set", {31'd0, bus.protocol_err}, 32'd1);
        chk("perr_no_strobes", {28'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.wait_n},
            32'b1111);
        bus.ram_cs   = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        tick();
        chk("perr_no_ce", 32'(ce_falls - c0), 32'd0);
        do_read(16'h1234, 8'hA5, 4, "post_perr");
        chk("perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

        // Reset while WE is low.
        a0 = acc_cnt;
        bus.address  = 16'h2222;
        bus.cpu_dout = 8'h77;
        bus.ram_cs   = 1'b1;
        bus.memwrite = 1'b1;
        repeat (2) tick();
        chk("rst_wr_pulse_reached", {31'd0, bus.sram_we_n}, 32'd0);
        reset        = 1'b1;
        bus.ram_cs   = 1'b0;
        bus.memwrite = 1'b0;
        tick();
        chk("rst_wr_strobes", {28'd0, bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe, bus.wait_n},
            32'b1101);
        chk("rst_wr_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_wr_dout", 32'(bus.ram_dout), 32'h00);
        chk("rst_wr_perr_clr", {31'd0, bus.protocol_err}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_wr_no_acc", 32'(acc_cnt - a0), 32'd0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("oe_interlock", 32'(interlock_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
